bcd_digit_serializer: RTL
=========================

BCD_DIGIT_SERIALIZER -- requirements
Module: bcd_digit_serializer

Interface
REQ-001 SHALL have parameter DIGIT, default 2, giving the number of packed BCD digits per input word (legal range 1..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: bcd_in is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-006 SHALL have port bcd_in, input, DIGIT*4 bits: packed BCD, digit 0 (least significant) in bits [3:0].
REQ-007 SHALL have port out_valid, output, 1 bit: out_digit is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: sink accepts the current digit.
REQ-009 SHALL have port out_digit, output, 4 bits: current BCD digit.
REQ-010 SHALL have port out_idx, output, clog2(DIGIT) bits (minimum 1): position of out_digit, 0 = least significant.
REQ-011 SHALL have port out_last, output, 1 bit: out_digit is digit 0, the final digit of the word.
REQ-012 SHALL have port out_err, output, 1 bit: out_digit value is greater than 9.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and SEND.
REQ-014 SHALL drive in_ready=1 only in IDLE; in_valid is ignored in SEND.
REQ-015 SHALL, on in_valid&&in_ready at edge T, register bcd_in, enter SEND and assert out_valid from T+1; latency is one cycle.
REQ-016 SHALL emit digits most-significant first: idx DIGIT-1 down to 0.
REQ-017 SHALL hold out_digit, out_idx, out_last and out_err stable while out_valid&&!out_ready.
REQ-018 SHALL advance to the next digit on each edge where out_valid&&out_ready, with no bubble cycles between digits.
REQ-019 SHALL assert out_last exactly when out_idx==0 and out_valid==1.
REQ-020 SHALL, on the handshake of the out_last digit, return to IDLE with out_valid=0 and in_ready=1 on the next cycle; no accept in the same cycle.
REQ-021 SHALL compute out_err combinationally as out_valid&&(out_digit>9); the digit is still emitted unmodified.
REQ-022 SHALL, when DIGIT==1, emit a single digit with out_last=1 and out_idx=0.
REQ-023 SHALL drive out_digit, out_idx, out_last and out_err to 0 whenever out_valid==0.

Reset
REQ-024 SHALL, with rst=1 at an edge, force IDLE, out_valid=0, in_ready=1, all other outputs 0, and clear the captured word.
REQ-025 SHALL, if rst is asserted mid-word, discard the remaining digits; no further digit of that word appears.
REQ-026 SHALL give rst priority over any simultaneous in or out handshake.

Configuration
REQ-027 SHALL support macro BCD_LZ_SUPPRESS_EN for leading-zero suppression.
REQ-028 SHALL, when BCD_LZ_SUPPRESS_EN is defined, start emission at the highest non-zero digit index, determined at capture so there is no skip cycle.
REQ-029 SHALL, when BCD_LZ_SUPPRESS_EN is defined and the word is all zeros, emit digit 0 only, with out_last=1.
REQ-030 SHALL, when BCD_LZ_SUPPRESS_EN is undefined, always emit all DIGIT digits.

Verification
REQ-031 SHALL test DIGIT=2, bcd_in=8'h47, out_ready=1: out_valid is seen at T+1 and T+2, digits 4 then 7, out_last on 7, in_ready=1 at T+3.
REQ-032 SHALL test DIGIT=3, bcd_in=12'h095, out_ready low for 3 cycles on the first digit: digit 0 is held stable for 4 cycles, then 9 and 5 follow. With BCD_LZ_SUPPRESS_EN, the sequence is 9 then 5.
REQ-033 SHALL test DIGIT=2, bcd_in=8'h00 with BCD_LZ_SUPPRESS_EN: a single digit 0 with out_idx=0 and out_last=1. Without the macro: 0,0.
REQ-034 SHALL test DIGIT=2, bcd_in=8'hA3: out_err=1 on digit A and 0 on digit 3.
REQ-035 SHALL test DIGIT=4, bcd_in=16'h1234, with rst pulsed after the second digit: out_valid=0 the next cycle, in_ready=1, and a new word 16'h5678 then emits 5,6,7,8.
REQ-036 SHALL test in_valid held high during SEND: no recapture occurs, and the held word is accepted only in the first IDLE cycle after the out_last handshake.

Source files
------------

// File: rtl/bcd_digit_serializer.sv
// ============================================================================
// Module   : bcd_digit_serializer
// Summary  : Captures a packed BCD word and streams its digits MSD-first over
//            a valid/ready interface, flagging non-decimal nibbles.
//            Optional macro BCD_LZ_SUPPRESS_EN skips leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_serializer #(
    parameter int DIGIT = 2,
    localparam int IDXW = (DIGIT > 1) ? $clog2(DIGIT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIGIT*4-1:0] bcd_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_digit,
    output logic [IDXW-1:0]    out_idx,
    output logic               out_last,
    output logic               out_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                state_q;
    logic [DIGIT*4-1:0]    word_q;
    logic [3:0]            digit_q;
    logic [IDXW-1:0]       idx_q;
    logic                  last_q;
    logic                  valid_q;
    logic                  ready_q;

    logic [IDXW-1:0]       start_idx_d;
    logic [IDXW-1:0]       next_idx_d;
    logic [3:0]            start_digit_d;
    logic [3:0]            next_digit_d;

    // First digit index is resolved at capture time so no cycle is spent skipping zeros.
    always_comb begin
`ifdef BCD_LZ_SUPPRESS_EN
        start_idx_d = '0;
        for (int i = 1; i < DIGIT; i++) begin
            if (bcd_in[4*i +: 4] != 4'd0) begin
                start_idx_d = IDXW'(i);
            end
        end
`else
        start_idx_d = IDXW'(DIGIT - 1);
`endif
    end

    assign next_idx_d = idx_q - 1'b1;

    always_comb begin
        start_digit_d = 4'd0;
        next_digit_d  = 4'd0;
        for (int i = 0; i < DIGIT; i++) begin
            if (start_idx_d == IDXW'(i)) begin
                start_digit_d = bcd_in[4*i +: 4];
            end
            if (next_idx_d == IDXW'(i)) begin
                next_digit_d = word_q[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            digit_q <= 4'd0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q <= S_SEND;
                        word_q  <= bcd_in;
                        digit_q <= start_digit_d;
                        idx_q   <= start_idx_d;
                        last_q  <= (start_idx_d == '0);
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (last_q) begin
                            state_q <= S_IDLE;
                            digit_q <= 4'd0;
                            idx_q   <= '0;
                            last_q  <= 1'b0;
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            digit_q <= next_digit_d;
                            idx_q   <= next_idx_d;
                            last_q  <= (next_idx_d == '0);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_digit = digit_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign out_err   = valid_q && (digit_q > 4'd9);

endmodule

`default_nettype wire
